rank_select: RTL and testbench

RANK_SELECT -- requirements
Module: rank_select

---
 rtl/rank_select_pkg.sv | 12 +
 rtl/rank_select_bitsum_tree.sv | 20 ++
 rtl/rank_select.sv | 134 +++++++++++++
 tb/tb_rank_select.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_select_pkg.sv
// Shared filter package: default window geometry and rank-field width derivation.
package rank_select_pkg;

  localparam int FILT_N      = 9;
  localparam int FILT_DATA_W = 8;

  // Width needed to hold any count 0..n inclusive.
  function automatic int rank_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rank_select_bitsum_tree.sv
// Rank-sum tree: counts the set bits of one sample's comparison vector.
module bitsum_tree
  import rank_select_pkg::*;
#(
  parameter int W     = 8,
  parameter int SUM_W = rank_width(W)
) (
  input  logic [W-1:0]     bits,
  output logic [SUM_W-1:0] sum
);

  // Population count; SUM_W is sized to hold W without overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < W; k++) begin
      sum = sum + SUM_W'(bits[k]);
    end
  end

endmodule

// File: rtl/rank_select.sv
// Rank selector: picks the sample of requested rank among enabled window samples.
// Three stages (compare, rank sum, select) advance together under one enable.
module rank_select
  import rank_select_pkg::*;
#(
  parameter int N      = FILT_N,
  parameter int DATA_W = FILT_DATA_W,
  parameter int RANK_W = rank_width(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_mask,
  input  logic [RANK_W-1:0]   in_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [N-1:0][DATA_W-1:0] x;
  assign x = in_data;

  // S1 signals
  logic [N-1:0][N-2:0]      vec_d;
  logic                     s1_valid;
  logic [N-1:0][N-2:0]      s1_vec;
  logic [N-1:0]             s1_mask;
  logic [RANK_W-1:0]        s1_target;
  logic [N-1:0][DATA_W-1:0] s1_data;

  // S2 signals
  logic [N-1:0][RANK_W-1:0] rank_d;
  logic [RANK_W-1:0]        m_d;
  logic                     s2_valid;
  logic [N-1:0][RANK_W-1:0] s2_rank;
  logic [RANK_W-1:0]        s2_m;
  logic [N-1:0]             s2_mask;
  logic [RANK_W-1:0]        s2_target;
  logic [N-1:0][DATA_W-1:0] s2_data;

  // S3 signals
  logic [DATA_W-1:0]        sel_d;
  logic                     err_d;

  // Pairwise compare: bit set when enabled sample j sorts before sample i (index breaks ties).
  always_comb begin
    vec_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          vec_d[i][(j < i) ? j : j - 1] = in_mask[j] &&
            ((x[j] < x[i]) || ((x[j] == x[i]) && (j < i)));
        end
      end
    end
  end

  // S1 register: comparison vectors plus the request context.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_vec    <= vec_d;
      s1_mask   <= in_mask;
      s1_target <= in_target;
      s1_data   <= x;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_rank
    bitsum_tree #(
      .W    (N - 1),
      .SUM_W(RANK_W)
    ) u_sum (
      .bits(s1_vec[g]),
      .sum (rank_d[g])
    );
  end

  // Number of enabled samples in the request.
  always_comb begin
    m_d = '0;
    for (int i = 0; i < N; i++) begin
      m_d = m_d + RANK_W'(s1_mask[i]);
    end
  end

  // S2 register: per-sample ranks and enabled count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_rank   <= rank_d;
      s2_m      <= m_d;
      s2_mask   <= s1_mask;
      s2_target <= s1_target;
      s2_data   <= s1_data;
    end
  end

  // Select: ranks of enabled samples are distinct, so at most one term is non-zero.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_mask[i] && (s2_rank[i] == s2_target)) begin
        sel_d = sel_d | s2_data[i];
      end
    end
    err_d = (s2_target >= s2_m);
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_data  <= err_d ? '0 : sel_d;
      out_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_rank_select.sv
// Bench for rank_select: directed cases plus random traffic against a sort-based model.
module tb_rank_select;

  localparam int N  = 9;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int N_RAND = 20000;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_mask;
  logic [RW-1:0]   in_target;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_err;

  always #5 clk = ~clk;

  rank_select dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_target(in_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } res_t;

  res_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            pops = 0;
  int            last_pop_cyc = -100;
  logic [DW-1:0] last_pop_d;
  logic          last_pop_e;
  logic          accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sort the enabled samples and index by target.
  function automatic res_t model(input logic [N*DW-1:0] d, input logic [N-1:0] m,
                                 input logic [RW-1:0] t);
    logic [DW-1:0] q[$];
    res_t r;
    for (int i = 0; i < N; i++) if (m[i]) q.push_back(d[i*DW +: DW]);
    q.sort();
    if (int'(t) >= q.size()) begin
      r.d = '0;
      r.e = 1'b1;
    end else begin
      r.d = q[t];
      r.e = 1'b0;
    end
    return r;
  endfunction

  // Drive one cycle at the falling edge, observe 1ns later, score accepts and results.
  task automatic step_cycle(input logic v, input logic [N*DW-1:0] d, input logic [N-1:0] m,
                            input logic [RW-1:0] t, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_mask   = m;
    in_target = t;
    out_ready = ordy;
    #1;
    accepted = v && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(out_valid), 0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(r.d));
        check("out_err", 32'(out_err), 32'(r.e));
        pops++;
        last_pop_cyc = cyc;
        last_pop_d   = out_data;
        last_pop_e   = out_err;
      end
    end
    if (accepted) exp_q.push_back(model(d, m, t));
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step_cycle(1'b0, '0, '0, '0, ordy);
  endtask

  task automatic send_and_expect(input string tag, input logic [N*DW-1:0] d,
                                 input logic [N-1:0] m, input logic [RW-1:0] t,
                                 input logic [DW-1:0] exp_d, input logic exp_e);
    int p0;
    int acc;
    p0 = pops;
    step_cycle(1'b1, d, m, t, 1'b1);
    acc = cyc - 1;
    check({tag, "_accept"}, 32'(accepted), 1);
    for (int k = 0; k < 8 && pops == p0; k++) idle(1'b1);
    check({tag, "_count"}, pops - p0, 1);
    check({tag, "_latency"}, last_pop_cyc - acc, 3);
    check({tag, "_data"}, 32'(last_pop_d), 32'(exp_d));
    check({tag, "_err"}, 32'(last_pop_e), 32'(exp_e));
  endtask

  function automatic logic [N*DW-1:0] rand_window();
    logic [N*DW-1:0] w;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       w[i*DW +: DW] = DW'($urandom_range(0, 255));
        1:       w[i*DW +: DW] = DW'($urandom_range(0, 3));
        default: w[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      endcase
    end
    return w;
  endfunction

  // Watchdog: the directed and random phases are all bounded, this only guards a hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] dd;
    logic [N*DW-1:0] reqd[5];
    logic [DW-1:0]   hold_d;
    logic            hold_e;
    int              p0;
    int              c0;
    int              idx;
    int              s;
    int              sent;
    logic            pend;
    logic [N*DW-1:0] pd;
    logic [N-1:0]    pm;
    logic [RW-1:0]   pt;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mask = '0;
    in_target = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // Descending window 9..1, median rank.
    for (int i = 0; i < N; i++) dd[i*DW +: DW] = DW'(9 - i);
    send_and_expect("desc_t4", dd, 9'h1FF, 4'd4, 8'd5, 1'b0);
    // Enabled subset {5,4,3,2} at samples 4..7; disabled smaller values must not match.
    send_and_expect("sub_t0", dd, 9'h0F0, 4'd0, 8'd2, 1'b0);
    send_and_expect("sub_t3", dd, 9'h0F0, 4'd3, 8'd5, 1'b0);
    send_and_expect("sub_t4", dd, 9'h0F0, 4'd4, 8'd0, 1'b1);

    // All equal: tie rule still yields ranks 0..8.
    for (int i = 0; i < N; i++) dd[i*DW +: DW] = 8'd7;
    send_and_expect("tie_t8", dd, 9'h1FF, 4'd8, 8'd7, 1'b0);
    send_and_expect("tie_t9", dd, 9'h1FF, 4'd9, 8'd0, 1'b1);

    // Empty and single-sample masks.
    for (int i = 0; i < N; i++) dd[i*DW +: DW] = 8'h11 * DW'(i);
    send_and_expect("m0_t0", dd, 9'h000, 4'd0, 8'd0, 1'b1);
    send_and_expect("m0_t5", dd, 9'h000, 4'd5, 8'd0, 1'b1);
    dd[DW-1:0] = 8'hAA;
    send_and_expect("m1_t0", dd, 9'h001, 4'd0, 8'hAA, 1'b0);
    send_and_expect("m1_t1", dd, 9'h001, 4'd1, 8'd0, 1'b1);

    // Five back-to-back requests drain in five consecutive cycles.
    p0 = pops;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      step_cycle(1'b1, rand_window(), 9'h1FF, RW'(k), 1'b1);
      check("b2b_accept", 32'(accepted), 1);
    end
    for (int k = 0; k < 12 && (pops - p0) < 5; k++) idle(1'b1);
    check("b2b_count", pops - p0, 5);
    check("b2b_last_cycle", last_pop_cyc - c0, 7);

    // Back-to-back offers with a 4-cycle consumer stall once results appear.
    for (int k = 0; k < 5; k++) reqd[k] = rand_window();
    p0 = pops;
    c0 = cyc;
    idx = 0;
    hold_d = '0;
    hold_e = 1'b0;
    for (int k = 0; k < 30 && (pops - p0) < 5; k++) begin
      s = cyc - c0;
      step_cycle(idx < 5, reqd[idx % 5], 9'h1FF, RW'(2 * (idx % 5)), !(s >= 3 && s <= 6));
      if (accepted) idx++;
      if (s >= 3 && s <= 6) begin
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        if (s == 3) begin
          hold_d = out_data;
          hold_e = out_err;
        end else begin
          check("stall_hold_data", 32'(out_data), 32'(hold_d));
          check("stall_hold_err", 32'(out_err), 32'(hold_e));
        end
      end
    end
    check("stall_count", pops - p0, 5);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset with two requests in flight.
    step_cycle(1'b1, rand_window(), 9'h1FF, 4'd1, 1'b1);
    step_cycle(1'b1, rand_window(), 9'h1FF, 4'd2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_data", 32'(out_data), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      check("post_rst_quiet", 32'(out_valid), 0);
    end

    // Random traffic with random consumer backpressure.
    sent = 0;
    pend = 1'b0;
    pd = '0;
    pm = '0;
    pt = '0;
    for (int k = 0; k < 80000 && sent < N_RAND; k++) begin
      if (!pend && $urandom_range(0, 4) != 0) begin
        pend = 1'b1;
        pd = rand_window();
        pm = ($urandom_range(0, 3) == 0) ? 9'h1FF : N'($urandom_range(0, 511));
        pt = RW'($urandom_range(0, 10));
      end
      step_cycle(pend, pd, pm, pt, $urandom_range(0, 3) != 0);
      if (accepted) begin
        pend = 1'b0;
        sent++;
      end
    end
    check("rand_sent", sent, N_RAND);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
    check("rand_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
